// File: rtl/addr_decode.sv
// Address decoder: maps an address onto a target index using a run-time map of
// half-open [start_addr, end_addr) rules. Optionally registers the result.
package addr_decode_pkg;
   typedef logic [31:0] addr_t;
   typedef struct packed {
      int unsigned idx;
      addr_t       start_addr;
      addr_t       end_addr;
   } rule_t;
endpackage

module addr_decode #(
   parameter int unsigned NoIndices  = 32'd1,
   parameter int unsigned NoRules    = 32'd1,
   parameter type         addr_t     = addr_decode_pkg::addr_t,
   parameter type         rule_t     = addr_decode_pkg::rule_t,
   parameter bit          Registered = 1'b0,
   parameter int unsigned IdxWidth   = (NoIndices > 1) ? $clog2(NoIndices) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  addr_t                      addr_i,
   input  rule_t [NoRules-1:0]        addr_map_i,
   input  logic                       en_default_idx_i,
   input  logic [IdxWidth-1:0]        default_idx_i,
   output logic [IdxWidth-1:0]        idx_o,
   output logic                       dec_valid_o,
   output logic                       dec_error_o
);

   logic [IdxWidth-1:0] w_idx;
   logic                w_valid;
   logic                w_error;
   logic [IdxWidth-1:0] w_match_idx;
   logic                w_match;
   logic                w_unused;

   // Upper idx bits and, in the combinational build, clk/rst are intentionally ignored.
   assign w_unused = ^{clk_i, rst_i, addr_map_i};

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_match     = 1'b0;
      w_match_idx = '0;
      // Later rules overwrite earlier ones, so the highest-numbered match wins.
      // An empty rule (start >= end) can never satisfy both compares.
      for (int i = 0; i < int'(NoRules); i++) begin
         if ((addr_i >= addr_map_i[i].start_addr) && (addr_i < addr_map_i[i].end_addr)) begin
            w_match     = 1'b1;
            w_match_idx = addr_map_i[i].idx[IdxWidth-1:0];
         end
      end
   end

   always_comb begin
      w_idx   = '0;
      w_valid = 1'b0;
      w_error = 1'b0;
      if (w_match) begin
         w_idx   = w_match_idx;
         w_valid = 1'b1;
      end else if (en_default_idx_i) begin
         w_idx   = default_idx_i;
      end else begin
         w_error = 1'b1;
      end
   end

   if (Registered) begin : g_reg
      logic [IdxWidth-1:0] r_idx;
      logic                r_valid;
      logic                r_error;

      // NOTE: sequential state uses non-blocking assignments so all flops sample together.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_error <= 1'b0;
         end else begin
            r_idx   <= w_idx;
            r_valid <= w_valid;
            r_error <= w_error;
         end
      end

      assign idx_o       = r_idx;
      assign dec_valid_o = r_valid;
      assign dec_error_o = r_error;
   end else begin : g_comb
      assign idx_o       = w_idx;
      assign dec_valid_o = w_valid;
      assign dec_error_o = w_error;
   end

   if (NoRules == 0) begin : g_chk_rules
      $fatal(1, "addr_decode: NoRules must be > 0");
   end
   if (NoIndices == 0) begin : g_chk_indices
      $fatal(1, "addr_decode: NoIndices must be > 0");
   end

`ifndef SYNTHESIS
   // Map sanity: out-of-range indices are errors, overlapping live rules only warn.
   always_comb begin
      for (int i = 0; i < int'(NoRules); i++) begin
         assert (addr_map_i[i].idx < NoIndices)
            else $error("addr_decode: rule %0d idx %0d out of range", i, addr_map_i[i].idx);
         for (int j = i + 1; j < int'(NoRules); j++) begin
            if ((addr_map_i[i].start_addr < addr_map_i[i].end_addr) &&
                (addr_map_i[j].start_addr < addr_map_i[j].end_addr) &&
                (addr_map_i[i].start_addr < addr_map_i[j].end_addr) &&
                (addr_map_i[j].start_addr < addr_map_i[i].end_addr)) begin
               $warning("addr_decode: rules %0d and %0d overlap", i, j);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_addr_decode.sv
// Directed bench for addr_decode: table of combinational vectors plus
// hand-written sequences for the registered variant's latency and reset.
module tb_addr_decode;
   typedef logic [31:0] addr_t;
   typedef struct packed {
      int unsigned idx;
      addr_t       start_addr;
      addr_t       end_addr;
   } rule_t;

   typedef struct {
      int          map_sel;
      addr_t       addr;
      logic        en_def;
      logic [1:0]  def_idx;
      logic [1:0]  exp_idx;
      logic        exp_valid;
      logic        exp_error;
   } vec_t;

   logic        clk;
   logic        rst;
   addr_t       addr;
   rule_t [3:0] map;
   logic        en_def;
   logic [1:0]  def_idx;
   logic [1:0]  c_idx, r_idx;
   logic        c_valid, r_valid, c_error, r_error;

   int checks = 0;
   int errors = 0;

   rule_t [3:0] maps [3];
   vec_t        vecs [16];

   addr_decode #(.NoIndices(4), .NoRules(4), .addr_t(addr_t), .rule_t(rule_t), .Registered(1'b0)) u_comb (
      .clk_i(clk), .rst_i(rst), .addr_i(addr), .addr_map_i(map),
      .en_default_idx_i(en_def), .default_idx_i(def_idx),
      .idx_o(c_idx), .dec_valid_o(c_valid), .dec_error_o(c_error));

   addr_decode #(.NoIndices(4), .NoRules(4), .addr_t(addr_t), .rule_t(rule_t), .Registered(1'b1)) u_reg (
      .clk_i(clk), .rst_i(rst), .addr_i(addr), .addr_map_i(map),
      .en_default_idx_i(en_def), .default_idx_i(def_idx),
      .idx_o(r_idx), .dec_valid_o(r_valid), .dec_error_o(r_error));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reg(input string name, input logic [1:0] idx, input logic valid, input logic error);
      check({name, " idx"},   32'(r_idx),   32'(idx));
      check({name, " valid"}, 32'(r_valid), 32'(valid));
      check({name, " error"}, 32'(r_error), 32'(error));
   endtask

   initial begin
      // Map 0: four adjacent 4-byte windows from 0x1000.
      for (int i = 0; i < 4; i++) begin
         maps[0][i] = '{idx: i, start_addr: 32'h1000 + 4 * i, end_addr: 32'h1004 + 4 * i};
      end
      // Map 1: overlapping rules 0 and 1; rules 2/3 empty.
      maps[1][0] = '{idx: 0, start_addr: 32'h0,   end_addr: 32'h100};
      maps[1][1] = '{idx: 1, start_addr: 32'h80,  end_addr: 32'h200};
      maps[1][2] = '{idx: 0, start_addr: 32'h0,   end_addr: 32'h0};
      maps[1][3] = '{idx: 0, start_addr: 32'h0,   end_addr: 32'h0};
      // Map 2: inverted rule that must never match.
      maps[2][0] = '{idx: 2, start_addr: 32'h200, end_addr: 32'h100};
      maps[2][1] = '{idx: 0, start_addr: 32'h0,   end_addr: 32'h0};
      maps[2][2] = '{idx: 0, start_addr: 32'h0,   end_addr: 32'h0};
      maps[2][3] = '{idx: 0, start_addr: 32'h0,   end_addr: 32'h0};

      //            map  addr           en    def    idx    valid error
      vecs[0]  = '{0, 32'h0000_1008, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0};
      vecs[1]  = '{0, 32'h0000_100C, 1'b0, 2'd0, 2'd3, 1'b1, 1'b0};
      vecs[2]  = '{0, 32'h0000_1010, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1};
      vecs[3]  = '{0, 32'h0000_0FFF, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1};
      vecs[4]  = '{0, 32'h0000_1004, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0};
      vecs[5]  = '{0, 32'h0000_1000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0};
      vecs[6]  = '{0, 32'h0000_100F, 1'b0, 2'd0, 2'd3, 1'b1, 1'b0};
      vecs[7]  = '{0, 32'h0000_1010, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0};
      vecs[8]  = '{0, 32'h0000_100C, 1'b1, 2'd1, 2'd3, 1'b1, 1'b0};
      vecs[9]  = '{1, 32'h0000_0090, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0};
      vecs[10] = '{1, 32'h0000_007F, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0};
      vecs[11] = '{1, 32'h0000_01FF, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0};
      vecs[12] = '{1, 32'h0000_0200, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1};
      vecs[13] = '{2, 32'h0000_0180, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1};
      vecs[14] = '{2, 32'h0000_0180, 1'b1, 2'd3, 2'd3, 1'b0, 1'b0};
      vecs[15] = '{0, 32'hFFFF_FFFF, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1};

      rst     = 1'b1;
      addr    = '0;
      map     = maps[0];
      en_def  = 1'b0;
      def_idx = '0;

      for (int i = 0; i < 16; i++) begin
         map     = maps[vecs[i].map_sel];
         addr    = vecs[i].addr;
         en_def  = vecs[i].en_def;
         def_idx = vecs[i].def_idx;
         #2;
         check($sformatf("v%0d idx", i),   32'(c_idx),   32'(vecs[i].exp_idx));
         check($sformatf("v%0d valid", i), 32'(c_valid), 32'(vecs[i].exp_valid));
         check($sformatf("v%0d error", i), 32'(c_error), 32'(vecs[i].exp_error));
         check($sformatf("v%0d exclusive", i), 32'(c_valid & c_error), 32'd0);
      end

      // Registered variant: reset hold, 1-cycle latency, async mid-stream reset.
      @(negedge clk);
      map     = maps[0];
      addr    = 32'h1008;
      en_def  = 1'b0;
      def_idx = '0;
      @(posedge clk); #1;
      check_reg("reg held in reset", 2'd0, 1'b0, 1'b0);

      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check_reg("reg first decode", 2'd2, 1'b1, 1'b0);

      @(negedge clk);
      addr = 32'h100C;
      #1;
      check_reg("reg latency hold", 2'd2, 1'b1, 1'b0);
      @(posedge clk); #1;
      check_reg("reg after edge", 2'd3, 1'b1, 1'b0);

      @(negedge clk);
      addr = 32'h1010;
      @(posedge clk); #1;
      check_reg("reg miss", 2'd0, 1'b0, 1'b1);

      @(negedge clk);
      addr = 32'h1008;
      @(posedge clk); #1;
      check_reg("reg pre-reset", 2'd2, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_reg("reg async clear", 2'd0, 1'b0, 1'b0);

      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reg("reg waits for edge", 2'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_reg("reg resumes", 2'd2, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
